// File: rtl/rggen_rtl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rggen_rtl_pkg : shared access/status encodings for rggen register buses.
// Revision: 1.0
// ---------------------------------------------------------------------------
package rggen_rtl_pkg;
  typedef enum logic [1:0] {
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_READ         = 2'b10,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;
endpackage
`default_nettype wire

// File: rtl/rggen_bus_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rggen_bus_if : generic valid/ready register bus between master and slave.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int STROBE_WIDTH  = BUS_WIDTH / 8
)();
  logic                     valid;
  rggen_access              access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [STROBE_WIDTH-1:0]  strobe;
  logic                     ready;
  rggen_status              status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface
`default_nettype wire

// File: rtl/rggen_bus_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rggen_bus_initiator : single-outstanding command/response master for rggen_bus_if.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rggen_bus_initiator
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 8,
  parameter int BUS_WIDTH       = 32,
  parameter int STROBE_WIDTH    = BUS_WIDTH / 8,
  parameter bit CHECK_ALIGNMENT = 1'b1,
  parameter int TIMEOUT_CYCLES  = 0
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_command_valid,
  output logic                     o_command_ready,
  input  rggen_access              i_command_access,
  input  logic [ADDRESS_WIDTH-1:0] i_command_address,
  input  logic [BUS_WIDTH-1:0]     i_command_write_data,
  input  logic [STROBE_WIDTH-1:0]  i_command_strobe,
  output logic                     o_response_valid,
  input  logic                     i_response_ready,
  output rggen_status              o_response_status,
  output logic [BUS_WIDTH-1:0]     o_response_read_data,
  output logic                     o_timeout,
  rggen_bus_if.master              bus_if
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  localparam int COUNTER_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [COUNTER_WIDTH-1:0] COUNTER_MAX = COUNTER_WIDTH'(TIMEOUT_CYCLES);
  localparam int ALIGN_BITS = $clog2(BUS_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'((1 << ALIGN_BITS) - 1);

  logic [1:0]               state;
  logic                     bus_valid;
  rggen_access              access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [STROBE_WIDTH-1:0]  strobe;
  rggen_status              response_status;
  logic [BUS_WIDTH-1:0]     response_data;
  logic [COUNTER_WIDTH-1:0] wait_count;

  logic command_ack;
  logic misaligned;

  assign o_command_ready = (state == IDLE) || ((state == RESPOND) && i_response_ready);
  assign command_ack     = i_command_valid && o_command_ready;
  assign misaligned      = CHECK_ALIGNMENT && ((i_command_address & ALIGN_MASK) != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      bus_valid       <= 1'b0;
      access          <= rggen_access'(2'b00);
      address         <= '0;
      write_data      <= '0;
      strobe          <= '0;
      response_status <= RGGEN_OKAY;
      response_data   <= '0;
      wait_count      <= '0;
    end else if (command_ack) begin
      access     <= i_command_access;
      address    <= i_command_address;
      write_data <= i_command_write_data;
      strobe     <= i_command_strobe;
      wait_count <= '0;
      if (misaligned) begin
        // Rejected locally: never reaches the bus
        state           <= RESPOND;
        bus_valid       <= 1'b0;
        response_status <= RGGEN_SLAVE_ERROR;
        response_data   <= '0;
      end else begin
        state     <= ISSUE;
        bus_valid <= 1'b1;
      end
    end else if (state == ISSUE) begin
      if (bus_if.ready) begin
        state           <= RESPOND;
        bus_valid       <= 1'b0;
        response_status <= bus_if.status;
        response_data   <= (access == RGGEN_READ) ? bus_if.read_data : '0;
      end else if (wait_count != COUNTER_MAX) begin
        wait_count <= wait_count + COUNTER_WIDTH'(1);
      end
    end else if ((state == RESPOND) && i_response_ready) begin
      state <= IDLE;
    end
  end

  assign o_response_valid     = (state == RESPOND);
  assign o_response_status    = response_status;
  assign o_response_read_data = response_data;
  assign o_timeout            = (TIMEOUT_CYCLES != 0) && (state == ISSUE) && (wait_count == COUNTER_MAX);

  assign bus_if.valid      = bus_valid;
  assign bus_if.access     = access;
  assign bus_if.address    = address;
  assign bus_if.write_data = write_data;
  assign bus_if.strobe     = strobe;
endmodule
`default_nettype wire

// File: tb/tb_rggen_bus_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rggen_bus_initiator : directed self-checking bench for rggen_bus_initiator.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_rggen_bus_initiator;
  import rggen_rtl_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  rggen_access cmd_access;
  logic [7:0]  cmd_address;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strobe;
  logic        rsp_valid;
  logic        rsp_ready;
  rggen_status rsp_status;
  logic [31:0] rsp_data;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int snap;

  rggen_bus_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .STROBE_WIDTH(4)) bus_if ();

  rggen_bus_initiator #(
    .ADDRESS_WIDTH   (8),
    .BUS_WIDTH       (32),
    .STROBE_WIDTH    (4),
    .CHECK_ALIGNMENT (1'b1),
    .TIMEOUT_CYCLES  (3)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_command_valid      (cmd_valid),
    .o_command_ready      (cmd_ready),
    .i_command_access     (cmd_access),
    .i_command_address    (cmd_address),
    .i_command_write_data (cmd_wdata),
    .i_command_strobe     (cmd_strobe),
    .o_response_valid     (rsp_valid),
    .i_response_ready     (rsp_ready),
    .o_response_status    (rsp_status),
    .o_response_read_data (rsp_data),
    .o_timeout            (timeout),
    .bus_if               (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus_if.valid === 1'b1) valid_cycles++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input rggen_access acc, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [3:0] strb);
    cmd_valid   = 1'b1;
    cmd_access  = acc;
    cmd_address = addr;
    cmd_wdata   = wd;
    cmd_strobe  = strb;
  endtask

  task automatic slave(input logic rdy, input rggen_status st, input logic [31:0] rd);
    bus_if.ready     = rdy;
    bus_if.status    = st;
    bus_if.read_data = rd;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_access = RGGEN_READ; cmd_address = '0; cmd_wdata = '0; cmd_strobe = '0;
    slave(1'b0, RGGEN_OKAY, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_bus_valid", bus_if.valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp", {rsp_status, rsp_data}, {RGGEN_OKAY, 32'h0});
    check("rst_timeout", timeout, 0);
    check("rst_req", {bus_if.address, bus_if.write_data, bus_if.strobe}, 0);

    // Aligned read, zero wait states
    snap = valid_cycles;
    send(RGGEN_READ, 8'h10, 32'h0, 4'hF);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rd_bus", {bus_if.valid, bus_if.access, bus_if.address}, {1'b1, RGGEN_READ, 8'h10});
    check("rd_rsp_early", rsp_valid, 0);
    slave(1'b1, RGGEN_OKAY, 32'hDEADBEEF);
    @(negedge clk);
    slave(1'b0, RGGEN_OKAY, 32'h0);
    check("rd_rsp", {rsp_valid, rsp_status, rsp_data}, {1'b1, RGGEN_OKAY, 32'hDEADBEEF});
    check("rd_bus_drop", bus_if.valid, 0);
    check("rd_valid_cycles", valid_cycles - snap, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rd_idle", {rsp_valid, cmd_ready}, 2'b01);

    // Write with four wait states
    snap = valid_cycles;
    send(RGGEN_WRITE, 8'h04, 32'h12345678, 4'h3);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wr_stable_%0d", i),
            {bus_if.valid, bus_if.access, bus_if.address, bus_if.write_data, bus_if.strobe},
            {1'b1, RGGEN_WRITE, 8'h04, 32'h12345678, 4'h3});
      if (i == 4) slave(1'b1, RGGEN_OKAY, 32'hFFFFFFFF);
      @(negedge clk);
    end
    slave(1'b0, RGGEN_OKAY, 32'h0);
    check("wr_rsp", {rsp_valid, rsp_status, rsp_data}, {1'b1, RGGEN_OKAY, 32'h0});
    check("wr_valid_cycles", valid_cycles - snap, 5);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Misaligned write rejected locally
    snap = valid_cycles;
    send(RGGEN_WRITE, 8'h06, 32'hAAAA5555, 4'hF);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mis_rsp", {bus_if.valid, rsp_valid, rsp_status, rsp_data},
          {1'b0, 1'b1, RGGEN_SLAVE_ERROR, 32'h0});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("mis_no_valid", valid_cycles - snap, 0);

    // Timeout after three stall cycles, valid held until ready
    send(RGGEN_READ, 8'h20, 32'h0, 4'hF);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      check($sformatf("to_cycle_%0d", i), {bus_if.valid, timeout}, {1'b1, (i >= 4)});
      if (i == 11) slave(1'b1, RGGEN_DECODE_ERROR, 32'hCAFEF00D);
      @(negedge clk);
    end
    slave(1'b0, RGGEN_OKAY, 32'h0);
    check("to_clear", {timeout, bus_if.valid}, 2'b00);
    check("to_rsp", {rsp_valid, rsp_status, rsp_data}, {1'b1, RGGEN_DECODE_ERROR, 32'hCAFEF00D});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Back-pressure with a pending second command, then back-to-back accept
    send(RGGEN_READ, 8'h08, 32'h0, 4'hF);
    @(negedge clk);
    send(RGGEN_WRITE, 8'h0C, 32'hA5A5A5A5, 4'hF);
    check("bp_issue_ready", cmd_ready, 0);
    slave(1'b1, RGGEN_OKAY, 32'h11111111);
    @(negedge clk);
    slave(1'b0, RGGEN_OKAY, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_%0d", i), {rsp_valid, rsp_status, rsp_data, cmd_ready, bus_if.valid},
            {1'b1, RGGEN_OKAY, 32'h11111111, 1'b0, 1'b0});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("b2b_bus", {bus_if.valid, bus_if.access, bus_if.address, bus_if.write_data, rsp_valid},
          {1'b1, RGGEN_WRITE, 8'h0C, 32'hA5A5A5A5, 1'b0});
    slave(1'b1, RGGEN_OKAY, 32'h77777777);
    @(negedge clk);
    slave(1'b0, RGGEN_OKAY, 32'h0);
    check("b2b_rsp", {rsp_valid, rsp_status, rsp_data}, {1'b1, RGGEN_OKAY, 32'h0});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during a stalled read
    send(RGGEN_READ, 8'h14, 32'h0, 4'hF);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_valid", bus_if.valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst", {bus_if.valid, rsp_valid, timeout}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(RGGEN_READ, 8'h18, 32'h0, 4'hF);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("post_rst_bus", {bus_if.valid, bus_if.address}, {1'b1, 8'h18});
    slave(1'b1, RGGEN_OKAY, 32'h55AA55AA);
    @(negedge clk);
    slave(1'b0, RGGEN_OKAY, 32'h0);
    check("post_rst_rsp", {rsp_valid, rsp_status, rsp_data}, {1'b1, RGGEN_OKAY, 32'h55AA55AA});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
